array_row_mult_sched: RTL and testbench

//  Sequencer and arbiter for one shared four-cell array multiplier row.

---
 rtl/array_row_mult_sched.sv | 160 ++++++++++++++++
 tb/tb_array_row_mult_sched.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/array_row_mult_sched.sv
// Arbitrated sequencer for one shared 4-cell array multiplier row: 4x4 unsigned products in four shift-add steps.
// Optional MULT_SCHED_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module array_row_mult_sched #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [4*NUM_REQ-1:0] req_a,
  input  logic [4*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 busy,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [7:0]           res_product,
  output logic [ID_W-1:0]      res_id,
  output logic [3:0]           row_a,
  output logic [3:0]           row_b,
  output logic [3:0]           row_sum_in,
  output logic                 row_c_in,
  input  logic [3:0]           row_sum,
  input  logic                 row_c_out
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [1:0]        step_q, step_d;
  logic [3:0]        a_q, a_d;
  logic [3:0]        b_q, b_d;
  logic [3:0]        p_hi_q, p_hi_d;
  logic [3:0]        p_lo_q, p_lo_d;
  logic [ID_W-1:0]   id_q, id_d;

  logic [3:0]        a_nib [NUM_REQ];
  logic [3:0]        b_nib [NUM_REQ];

  logic              gnt_found;
  logic [PTR_W-1:0]  gnt_idx;
  logic [PTR_W:0]    cand;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_nib
    assign a_nib[gi] = req_a[4*gi +: 4];
    assign b_nib[gi] = req_b[4*gi +: 4];
  end

  // Rotating search from rr_ptr; the extra bit in cand absorbs the wrap before folding back.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
      if (cand >= (PTR_W+1)'(NUM_REQ)) begin
        cand = cand - (PTR_W+1)'(NUM_REQ);
      end
      if (!gnt_found && req_valid[cand[PTR_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    step_d    = step_q;
    a_d       = a_q;
    b_d       = b_q;
    p_hi_d    = p_hi_q;
    p_lo_d    = p_lo_q;
    id_d      = id_q;
    req_ready = '0;

    case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          req_ready[gnt_idx] = 1'b1;
          a_d     = a_nib[gnt_idx];
          b_d     = b_nib[gnt_idx];
          p_hi_d  = 4'd0;
          p_lo_d  = 4'd0;
          id_d    = ID_W'(gnt_idx);
          step_d  = 2'd0;
          state_d = S_RUN;
`ifdef MULT_SCHED_FIXED_PRIO_EN
          rr_ptr_d = '0;
`else
          if (gnt_idx == PTR_W'(NUM_REQ - 1)) begin
            rr_ptr_d = '0;
          end else begin
            rr_ptr_d = gnt_idx + PTR_W'(1);
          end
`endif
        end
      end
      S_RUN: begin
        // Row adds the selected multiplicand to P_hi; result shifts right, dropping one product bit into P_lo.
        {p_hi_d, p_lo_d} = {row_c_out, row_sum, p_lo_q[3:1]};
        step_d = step_q + 2'd1;
        if (step_q == 2'd3) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (reset) begin
      req_ready = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      step_q   <= 2'd0;
      a_q      <= 4'd0;
      b_q      <= 4'd0;
      p_hi_q   <= 4'd0;
      p_lo_q   <= 4'd0;
      id_q     <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      step_q   <= step_d;
      a_q      <= a_d;
      b_q      <= b_d;
      p_hi_q   <= p_hi_d;
      p_lo_q   <= p_lo_d;
      id_q     <= id_d;
    end
  end

  assign busy        = (state_q == S_RUN) || (state_q == S_DONE);
  assign res_valid   = (state_q == S_DONE);
  assign res_product = {p_hi_q, p_lo_q};
  assign res_id      = id_q;

  assign row_a      = {4{a_q[step_q]}};
  assign row_b      = b_q;
  assign row_sum_in = p_hi_q;
  assign row_c_in   = 1'b0;

endmodule

// File: tb/tb_array_row_mult_sched.sv
// Scoreboard bench for array_row_mult_sched with a behavioural model of the shared multiplier row.
module tb_array_row_mult_sched;

  localparam int NUM_REQ = 2;
  localparam int ID_W    = 1;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [4*NUM_REQ-1:0] req_a = '0;
  logic [4*NUM_REQ-1:0] req_b = '0;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 busy;
  logic                 res_valid;
  logic                 res_ready = 1'b1;
  logic [7:0]           res_product;
  logic [ID_W-1:0]      res_id;
  logic [3:0]           row_a, row_b, row_sum_in, row_sum;
  logic                 row_c_in, row_c_out;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [7:0]      prod;
  } exp_t;
  exp_t sb[$];

  always #5 clock = ~clock;

  // One row of AND gates feeding a 4-bit ripple adder.
  assign {row_c_out, row_sum} = {1'b0, (row_a & row_b)} + {1'b0, row_sum_in} + {4'b0, row_c_in};

  array_row_mult_sched #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
    .res_product(res_product), .res_id(res_id),
    .row_a(row_a), .row_b(row_b), .row_sum_in(row_sum_in), .row_c_in(row_c_in),
    .row_sum(row_sum), .row_c_out(row_c_out)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_req(input int i, input logic [3:0] a, input logic [3:0] b);
    exp_t e;
    req_valid[i]     = 1'b1;
    req_a[4*i +: 4]  = a;
    req_b[4*i +: 4]  = b;
    e.id   = ID_W'(i);
    e.prod = 8'(a) * 8'(b);
    sb.push_back(e);
  endtask

  task automatic wait_grant(input int i, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (req_ready[i]) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic accept(input int i);
    tick();
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_valid(output bit seen, output int cyc);
    cyc = 0;
    while (!res_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    seen = res_valid;
  endtask

  function automatic exp_t pop_exp();
    exp_t e;
    e = '0;
    if (sb.size() > 0) e = sb.pop_front();
    return e;
  endfunction

  task automatic test_reset();
    req_valid = 2'b01;
    tick(); tick();
    n_vec++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL reset_ready: got %b expected 00", req_ready); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_vec++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", res_valid); end
    n_vec++; if (res_product !== 8'd0) begin n_err++; $display("FAIL reset_product: got %0d expected 0", res_product); end
    n_vec++; if (res_id !== '0) begin n_err++; $display("FAIL reset_id: got %0d expected 0", res_id); end
    req_valid = '0;
    reset = 1'b0;
    tick();
    $display("reset: checks done");
  endtask

  task automatic test_single();
    bit ok; bit seen; int cyc; exp_t e;
    drive_req(0, 4'd15, 4'd15);
    wait_grant(0, ok);
    n_vec++; if (!ok || req_ready !== 2'b01) begin n_err++; $display("FAIL single_grant: got %b expected 01", req_ready); end
    accept(0);
    n_vec++; if (req_ready !== 2'b00 || busy !== 1'b1) begin n_err++; $display("FAIL single_run: ready %b busy %b expected 00/1", req_ready, busy); end
    wait_valid(seen, cyc);
    e = pop_exp();
    n_vec++; if (!seen || cyc != 4) begin n_err++; $display("FAIL single_latency: got %0d expected 4", cyc); end
    n_vec++; if (res_product !== e.prod || res_id !== e.id) begin n_err++; $display("FAIL single_result: got %0d/id%0d expected %0d/id%0d", res_product, res_id, e.prod, e.id); end
    tick();
    n_vec++; if (res_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL single_idle: valid %b busy %b expected 0/0", res_valid, busy); end
    $display("single: 15x15 -> %0d id %0d", e.prod, e.id);
  endtask

  task automatic test_zero();
    logic [3:0] ta [3] = '{4'd0, 4'd9, 4'd1};
    logic [3:0] tb [3] = '{4'd9, 4'd0, 4'd13};
    bit ok; bit seen; int cyc; exp_t e;
    for (int t = 0; t < 3; t++) begin
      drive_req(0, ta[t], tb[t]);
      wait_grant(0, ok);
      accept(0);
      wait_valid(seen, cyc);
      e = pop_exp();
      n_vec++;
      if (!ok || !seen || res_product !== e.prod || res_id !== e.id) begin
        n_err++; $display("FAIL zero_op%0d: got %0d/id%0d expected %0d/id%0d", t, res_product, res_id, e.prod, e.id);
      end
      $display("zero: %0dx%0d -> %0d", ta[t], tb[t], res_product);
      tick();
    end
  endtask

  task automatic test_contention();
    bit seen; int cyc; exp_t e; logic [1:0] exp_rdy;
    reset = 1'b1;
    req_valid = 2'b11;
    req_a = {4'd7, 4'd3};
    req_b = {4'd6, 4'd5};
    tick(); tick();
    reset = 1'b0;
    for (int n = 0; n < 4; n++) begin
`ifdef MULT_SCHED_FIXED_PRIO_EN
      e.id = 1'b0;
`else
      e.id = ID_W'(n % 2);
`endif
      e.prod = (e.id == 1'b0) ? 8'd15 : 8'd42;
      sb.push_back(e);
    end
    for (int n = 0; n < 4; n++) begin
      for (int c = 0; c < 20; c++) begin
        #1;
        if (req_ready != 2'b00) break;
        tick();
      end
      e = pop_exp();
      exp_rdy = (e.id == 1'b0) ? 2'b01 : 2'b10;
      n_vec++; if (req_ready !== exp_rdy) begin n_err++; $display("FAIL contention_grant%0d: got %b expected %b", n, req_ready, exp_rdy); end
      tick();
      wait_valid(seen, cyc);
      n_vec++;
      if (!seen || res_product !== e.prod || res_id !== e.id || req_ready !== 2'b00) begin
        n_err++; $display("FAIL contention_result%0d: got %0d/id%0d rdy %b expected %0d/id%0d rdy 00", n, res_product, res_id, req_ready, e.prod, e.id);
      end
      $display("contention: txn %0d id %0d product %0d", n, res_id, res_product);
      tick();
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_backpressure();
    bit ok; bit seen; int cyc; exp_t e;
    drive_req(1, 4'd9, 4'd11);
    wait_grant(1, ok);
    accept(1);
    res_ready = 1'b0;
    drive_req(0, 4'd2, 4'd2);
    wait_valid(seen, cyc);
    e = pop_exp();
    for (int c = 0; c < 10; c++) begin
      n_vec++;
      if (!seen || res_valid !== 1'b1 || res_product !== e.prod || res_id !== e.id || req_ready !== 2'b00) begin
        n_err++; $display("FAIL backpressure_hold%0d: got v%b %0d/id%0d rdy %b expected v1 %0d/id%0d rdy 00", c, res_valid, res_product, res_id, req_ready, e.prod, e.id);
      end
      tick();
    end
    res_ready = 1'b1;
    tick();
    n_vec++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL backpressure_release: valid %b expected 0", res_valid); end
    $display("backpressure: 9x11 -> %0d held 10 cycles", e.prod);
    wait_grant(0, ok);
    accept(0);
    wait_valid(seen, cyc);
    e = pop_exp();
    n_vec++; if (!ok || !seen || res_product !== e.prod || res_id !== e.id) begin n_err++; $display("FAIL backpressure_next: got %0d/id%0d expected %0d/id%0d", res_product, res_id, e.prod, e.id); end
    $display("backpressure: pending 2x2 -> %0d", res_product);
    tick();
  endtask

  task automatic test_reset_mid_run();
    bit ok; bit seen; int cyc; exp_t e;
    drive_req(0, 4'd5, 4'd5);
    wait_grant(0, ok);
    accept(0);
    tick(); tick();
    reset = 1'b1;
    req_valid = 2'b11;
    tick();
    n_vec++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || req_ready !== 2'b00) begin
      n_err++; $display("FAIL midrun_reset: busy %b valid %b rdy %b expected 0/0/00", busy, res_valid, req_ready);
    end
    void'(sb.pop_back());
    req_valid = '0;
    reset = 1'b0;
    tick();
    drive_req(0, 4'd2, 4'd8);
    drive_req(1, 4'd1, 4'd1);
    wait_grant(0, ok);
    n_vec++; if (!ok || req_ready !== 2'b01) begin n_err++; $display("FAIL midrun_ptr: got %b expected 01", req_ready); end
    accept(0);
    wait_valid(seen, cyc);
    e = pop_exp();
    n_vec++; if (!seen || res_product !== e.prod || res_id !== e.id) begin n_err++; $display("FAIL midrun_after: got %0d/id%0d expected %0d/id%0d", res_product, res_id, e.prod, e.id); end
    $display("midrun: 2x8 after abort -> %0d", res_product);
    tick();
    wait_grant(1, ok);
    accept(1);
    wait_valid(seen, cyc);
    e = pop_exp();
    n_vec++; if (!ok || !seen || res_product !== e.prod || res_id !== e.id) begin n_err++; $display("FAIL midrun_drain: got %0d/id%0d expected %0d/id%0d", res_product, res_id, e.prod, e.id); end
    tick();
  endtask

  task automatic test_exhaustive();
    bit ok; bit seen; int cyc; exp_t e;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        drive_req(1, 4'(a), 4'(b));
        wait_grant(1, ok);
        accept(1);
        wait_valid(seen, cyc);
        e = pop_exp();
        n_vec++;
        if (!ok || !seen || cyc != 4 || res_product !== e.prod || res_id !== e.id) begin
          n_err++; $display("FAIL exhaustive_%0dx%0d: got %0d/id%0d lat %0d expected %0d/id%0d lat 4", a, b, res_product, res_id, cyc, e.prod, e.id);
        end
        $display("exhaustive: %0dx%0d -> %0d id %0d", a, b, res_product, res_id);
        tick();
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_zero();
    test_contention();
    test_backpressure();
    test_reset_mid_run();
    test_exhaustive();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
